output_holder: RTL and testbench

//  Buffers cipher-core output bytes and presents them on the chip output pins, one byte per pin handshake.
//  - Sits between the cipher core and interface_fsm; produces interface_fsm's output_is_ready input.
//  - Consumes interface_fsm's interface_state_out.
//  - Small FIFO decouples core throughput from the slow external request/acknowledge handshake.

---
 rtl/output_holder.sv | 152 +++++++++++++++
 tb/tb_output_holder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/output_holder.sv
// Output holder: small FIFO between the cipher core and the output pins, popped by the pin handshake.
// Optional build macro OUTPUT_HOLDER_PARITY_EN stores per-byte even parity and adds data_out_parity.
package output_holder_pkg;
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PROCESSING = 2'd1,
        DONE       = 2'd2
    } interface_state_t;
endpackage

module output_holder
    import output_holder_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  interface_state_t         interface_state,
    input  logic [DATA_W-1:0]        core_data,
    input  logic                     core_valid,
    output logic                     core_ready,
    input  logic                     flush,
    input  logic                     pop_ack,
    output logic                     output_is_ready,
    output logic [DATA_W-1:0]        data_out,
`ifdef OUTPUT_HOLDER_PARITY_EN
    output logic                     data_out_parity,
`endif
    output logic                     data_out_valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
`ifdef OUTPUT_HOLDER_PARITY_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
`ifdef OUTPUT_HOLDER_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic               push, pop, load;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    // core_ready looks only at the registered level so a same-cycle pop never frees a slot early.
    assign core_ready      = (level_q != LVL_FULL);
    assign output_is_ready = (level_q != '0);

    assign push = core_valid && core_ready;
    assign pop  = (interface_state == DONE) && pop_ack && valid_q;
    assign load = (interface_state == PROCESSING) && (level_q != '0) && !valid_q;

`ifdef OUTPUT_HOLDER_PARITY_EN
    assign wr_entry = {^core_data, core_data};
`else
    assign wr_entry = core_data;
`endif
    assign rd_entry = mem[rd_ptr_q];

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
`ifdef OUTPUT_HOLDER_PARITY_EN
        parity_d   = parity_q;
`endif
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            data_out_d = '0;
            valid_d    = 1'b0;
`ifdef OUTPUT_HOLDER_PARITY_EN
            parity_d   = 1'b0;
`endif
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                data_out_d = '0;
                valid_d    = 1'b0;
`ifdef OUTPUT_HOLDER_PARITY_EN
                parity_d   = 1'b0;
`endif
            end else if (load) begin
                data_out_d = rd_entry[DATA_W-1:0];
                valid_d    = 1'b1;
`ifdef OUTPUT_HOLDER_PARITY_EN
                parity_d   = rd_entry[DATA_W];
`endif
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
`ifdef OUTPUT_HOLDER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
`ifdef OUTPUT_HOLDER_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage is not reset; the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= wr_entry;
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign level          = level_q;
`ifdef OUTPUT_HOLDER_PARITY_EN
    assign data_out_parity = parity_q;
`endif

    a_level_bound: assert property (@(posedge clk) disable iff (!nrst) level_q <= LVL_FULL);
    a_no_empty_pop: assert property (@(posedge clk) disable iff (!nrst) !(pop && level_q == '0));

endmodule

// File: tb/tb_output_holder.sv
// Randomized scoreboard bench for output_holder; drives interface_state as the interface FSM would.
module tb_output_holder;
    import output_holder_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    interface_state_t st = IDLE;
    logic [7:0]       core_data = '0;
    logic             core_valid = 1'b0;
    logic             core_ready;
    logic             flush = 1'b0;
    logic             pop_ack = 1'b0;
    logic             output_is_ready;
    logic [7:0]       data_out;
    logic             data_out_valid;
    logic [2:0]       level;
`ifdef OUTPUT_HOLDER_PARITY_EN
    logic             data_out_parity;
`endif

    output_holder #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst), .interface_state(st),
        .core_data(core_data), .core_valid(core_valid), .core_ready(core_ready),
        .flush(flush), .pop_ack(pop_ack), .output_is_ready(output_is_ready),
        .data_out(data_out),
`ifdef OUTPUT_HOLDER_PARITY_EN
        .data_out_parity(data_out_parity),
`endif
        .data_out_valid(data_out_valid), .level(level)
    );

    always #5 clk = ~clk;

    // Reference model: occupancy, whether a byte is on the pins, and expected presentation order.
    int         m_level = 0;
    bit         m_pres  = 0;
    logic [7:0] sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks flags every cycle and pops the scoreboard whenever a new byte appears.
    logic       prev_v = 1'b0;
    logic [7:0] prev_d = '0;
    always @(negedge clk) begin
        logic [7:0] e;
        chk("level", 32'(level), 32'(m_level));
        chk("core_ready", 32'(core_ready), 32'(m_level != DEPTH));
        chk("output_is_ready", 32'(output_is_ready), 32'(m_level != 0));
        chk("data_out_valid", 32'(data_out_valid), 32'(m_pres));
        if (data_out_valid && !prev_v) begin
            if (sb_q.size() == 0) chk("unexpected_byte", 32'(data_out_valid), 32'd0);
            else begin
                e = sb_q.pop_front();
                chk("data_out", 32'(data_out), 32'(e));
`ifdef OUTPUT_HOLDER_PARITY_EN
                chk("data_out_parity", 32'(data_out_parity), 32'(^e));
`endif
            end
        end else if (data_out_valid) begin
            chk("data_out_hold", 32'(data_out), 32'(prev_d));
        end else begin
            chk("data_out_idle", 32'(data_out), 32'd0);
`ifdef OUTPUT_HOLDER_PARITY_EN
            chk("parity_idle", 32'(data_out_parity), 32'd0);
`endif
        end
        prev_v = data_out_valid;
        prev_d = data_out;
    end

    task automatic cyc(input bit v, input logic [7:0] d, input interface_state_t s,
                       input bit a, input bit f);
        bit push, pop, load;
        core_valid = v; core_data = d; st = s; pop_ack = a; flush = f;
        push = v && (m_level < DEPTH);
        pop  = (s == DONE) && a && m_pres;
        load = (s == PROCESSING) && (m_level != 0) && !m_pres;
        @(posedge clk);
        if (f) begin
            m_level = 0; m_pres = 0; sb_q.delete();
        end else begin
            if (push) begin m_level++; sb_q.push_back(d); end
            if (pop) begin m_level--; m_pres = 0; end
            else if (load) m_pres = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        core_valid = 0; pop_ack = 0; flush = 0; st = IDLE;
        nrst = 0;
        m_level = 0; m_pres = 0; sb_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1 nrst = 1;
    endtask

    // One handshake as the interface FSM would sequence it: IDLE, PROCESSING, DONE..ack, IDLE.
    task automatic txn(input bit rnd);
        int guard = 0;
        int n;
        n = rnd ? int'($urandom_range(0, 3)) : 0;
        for (int i = 0; i < n; i++)
            cyc(rnd && $urandom_range(0, 1) == 1, 8'($urandom), IDLE, 0,
                rnd && $urandom_range(0, 39) == 0);
        while (m_level == 0 && guard < 20) begin
            cyc(1, 8'($urandom), IDLE, 0, 0);
            guard++;
        end
        chk("wait_data_timeout", 32'(m_level != 0), 32'd1);
        cyc(rnd && $urandom_range(0, 1) == 1, 8'($urandom), PROCESSING, 0, 0);
        n = rnd ? int'($urandom_range(1, 3)) : 1;
        for (int i = 1; i <= n; i++)
            cyc(rnd && $urandom_range(0, 1) == 1, 8'($urandom), DONE, i == n,
                rnd && i == n && $urandom_range(0, 19) == 0);
        cyc(0, 8'h00, IDLE, 0, 0);
    endtask

    initial begin
        do_reset();
        chk("t1_core_ready", 32'(core_ready), 32'd1);
        chk("t1_out_ready", 32'(output_is_ready), 32'd0);
        chk("t1_level", 32'(level), 32'd0);
        chk("t1_data_out", 32'(data_out), 32'h00);

        cyc(1, 8'hA5, IDLE, 0, 0);
        cyc(0, 8'h00, PROCESSING, 0, 0);
        cyc(0, 8'h00, DONE, 0, 0);
        chk("t2_first_done_data", 32'(data_out), 32'hA5);
        cyc(0, 8'h00, DONE, 1, 0);
        cyc(0, 8'h00, IDLE, 0, 0);
        chk("t2_level_after_pop", 32'(level), 32'd0);
        chk("t2_data_after_pop", 32'(data_out), 32'h00);

        for (int i = 1; i <= 5; i++) cyc(1, 8'(i), IDLE, 0, 0);
        chk("t3_level_full", 32'(level), 32'd4);
        chk("t3_core_ready", 32'(core_ready), 32'd0);
        cyc(0, 8'h00, PROCESSING, 0, 0);
        cyc(1, 8'h55, DONE, 1, 0);
        chk("t4_no_push_when_full", 32'(level), 32'd3);
        cyc(1, 8'h66, IDLE, 0, 0);
        chk("t4_push_after_pop", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) txn(0);
        chk("t3_drained", 32'(level), 32'd0);

        cyc(1, 8'h11, IDLE, 0, 0);
        cyc(1, 8'h22, IDLE, 0, 0);
        cyc(0, 8'h00, PROCESSING, 0, 0);
        cyc(1, 8'h77, DONE, 1, 1);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_valid", 32'(data_out_valid), 32'd0);
        cyc(0, 8'h00, IDLE, 0, 0);

        for (int i = 0; i < 3; i++) cyc(1, 8'(8'h30 + i), IDLE, 0, 0);
        cyc(0, 8'h00, PROCESSING, 0, 0);
        cyc(0, 8'h00, DONE, 0, 0);
        do_reset();
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_valid", 32'(data_out_valid), 32'd0);
        chk("t6_core_ready", 32'(core_ready), 32'd1);
        cyc(1, 8'h07, IDLE, 0, 0);
        txn(0);

        for (int i = 0; i < 300; i++) txn(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
